// File: rtl/unsigned_mul_8x8_ha_reduce_pipe_pkg.sv
// ha_reduce_pkg
// Shared constants, the half-adder row record and the row weighting helper
// for the final-reduction stage of the 8x8 approximate multipliers.
package ha_reduce_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int ROW_SHIFT = 2;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int ROW_W     = 10;
  localparam int PROD_W    = 16;
  localparam int SUM_W     = 17;
  // Pair sum row_a + (row_b << 2) peaks at 5095, which needs 13 bits.
  localparam int PAIR_W    = ROW_W + ROW_SHIFT + 1;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [B_W-1:0] b;
  } row_t;

  // Carry bits sit two positions above the top bits of the same row.
  function automatic logic [ROW_W-1:0] row_value(input row_t r);
    return ROW_W'(r.t) + (ROW_W'(r.b) << ROW_SHIFT);
  endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_reduce_pipe_if.sv
// unsigned_mul_8x8_ha_reduce_pipe_if
// Row-set input handshake plus product output handshake.
//   master : upstream/downstream side (drives rows, in_valid, out_ready)
//   slave  : reduction pipe (drives in_ready, out_valid, product, sat)
interface unsigned_mul_8x8_ha_reduce_pipe_if;
  import ha_reduce_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [T_W-1:0]    ha_array_0_t;
  logic [T_W-1:0]    ha_array_1_t;
  logic [T_W-1:0]    ha_array_2_t;
  logic [T_W-1:0]    ha_array_3_t;
  logic [B_W-1:0]    ha_array_0_b;
  logic [B_W-1:0]    ha_array_1_b;
  logic [B_W-1:0]    ha_array_2_b;
  logic [B_W-1:0]    ha_array_3_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              sat;

  modport master (
    output in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    input  in_ready, out_valid, product, sat
  );

  modport slave (
    input  in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    output in_ready, out_valid, product, sat
  );

endinterface

// File: rtl/unsigned_mul_8x8_ha_reduce_pipe_stage.sv
// ha_reduce_stage
// Generic valid/ready register slice.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake, in_data loaded on accept
//   out_valid/out_ready : downstream handshake, out_data registered
// in_ready depends only on local state and out_ready, never on in_valid.
module ha_reduce_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  // When the slice is free but nothing arrives, only the valid bit drops;
  // the data register keeps its last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_reduce_pipe.sv
// unsigned_mul_8x8_ha_reduce_pipe
// Weights four half-adder rows by bit position and sums them into a
// saturated 16-bit product through two valid/ready register stages.
//   clk   : clock
//   rst_n : async active-low reset
//   bus   : slave side of the row/product handshake interface
module unsigned_mul_8x8_ha_reduce_pipe
  import ha_reduce_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  unsigned_mul_8x8_ha_reduce_pipe_if.slave    bus
);

  logic [ROW_W-1:0]   row_v [NUM_ROWS];
  logic [PAIR_W-1:0]  s01_c;
  logic [PAIR_W-1:0]  s23_c;

  always_comb begin
    row_v[0] = row_value(row_t'{t: bus.ha_array_0_t, b: bus.ha_array_0_b});
    row_v[1] = row_value(row_t'{t: bus.ha_array_1_t, b: bus.ha_array_1_b});
    row_v[2] = row_value(row_t'{t: bus.ha_array_2_t, b: bus.ha_array_2_b});
    row_v[3] = row_value(row_t'{t: bus.ha_array_3_t, b: bus.ha_array_3_b});
  end

  assign s01_c = PAIR_W'(row_v[0]) + (PAIR_W'(row_v[1]) << ROW_SHIFT);
  assign s23_c = PAIR_W'(row_v[2]) + (PAIR_W'(row_v[3]) << ROW_SHIFT);

  logic                    v1;
  logic [2*PAIR_W-1:0]     d1;
  logic                    s2_free;

  ha_reduce_stage #(.W(2*PAIR_W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  ({s01_c, s23_c}),
    .out_valid(v1),
    .out_ready(s2_free),
    .out_data (d1)
  );

  logic [PAIR_W-1:0]  s01_q;
  logic [PAIR_W-1:0]  s23_q;
  logic [SUM_W-1:0]   sum_c;
  logic               sat_c;
  logic [PROD_W-1:0]  prod_c;

  assign s01_q = d1[2*PAIR_W-1:PAIR_W];
  assign s23_q = d1[PAIR_W-1:0];

  // Pair 2/3 carries row weight 2^4 relative to pair 0/1.
  assign sum_c  = SUM_W'(s01_q) + (SUM_W'(s23_q) << (2*ROW_SHIFT));
  assign sat_c  = sum_c[SUM_W-1];
  assign prod_c = sat_c ? {PROD_W{1'b1}} : sum_c[PROD_W-1:0];

  ha_reduce_stage #(.W(PROD_W+1)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v1),
    .in_ready (s2_free),
    .in_data  ({sat_c, prod_c}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data ({bus.sat, bus.product})
  );

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reduce_pipe.sv
module tb_unsigned_mul_8x8_ha_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_reduce_pipe_if bus ();

  unsigned_mul_8x8_ha_reduce_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     p;
    logic            s;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: every bit simply carries its positional weight.
  function automatic int ref_sum(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += int'(t[k]) * (1 << (2*k)) + int'(b[k]) * (1 << (2*k+2));
    return s;
  endfunction

  // Scoreboard on the falling edge, where all handshakes have settled.
  int  exp_q [$];
  bit  prev_stall = 0;
  int  prev_word = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      int word;
      word = {15'd0, bus.sat, bus.product};
      if (prev_stall && bus.out_valid) chk("stall_hold", word, prev_word);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_out", 1, 0);
        else chk("sb_product", word, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        int s;
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        t = {bus.ha_array_3_t, bus.ha_array_2_t, bus.ha_array_1_t, bus.ha_array_0_t};
        b = {bus.ha_array_3_b, bus.ha_array_2_b, bus.ha_array_1_b, bus.ha_array_0_b};
        s = ref_sum(t, b);
        exp_q.push_back(s > 65535 ? (65535 | (1 << 16)) : s);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = word;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    bus.ha_array_0_t = t[0]; bus.ha_array_1_t = t[1];
    bus.ha_array_2_t = t[2]; bus.ha_array_3_t = t[3];
    bus.ha_array_0_b = b[0]; bus.ha_array_1_b = b[1];
    bus.ha_array_2_b = b[2]; bus.ha_array_3_b = b[3];
  endtask

  task automatic send_check(input vec_t v, input string nm);
    drive(v.t, v.b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk({nm, "_valid_early"}, int'(bus.out_valid), 0);
    step();
    chk({nm, "_valid"}, int'(bus.out_valid), 1);
    chk({nm, "_product"}, int'(bus.product), int'(v.p));
    chk({nm, "_sat"}, int'(bus.sat), int'(v.s));
    step();
    chk({nm, "_drained"}, int'(bus.out_valid), 0);
  endtask

  function automatic vec_t mk(input logic [3:0][8:0] t, input logic [3:0][6:0] b,
                              input logic [15:0] p, input logic s);
    vec_t v;
    v.t = t; v.b = b; v.p = p; v.s = s;
    return v;
  endfunction

  initial begin
    #20000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [3:0][8:0] tz;
    logic [3:0][6:0] bz;
    int guard;
    tz = '0; bz = '0;

    vecs[0] = mk({9'd0, 9'd0, 9'd0, 9'd1}, bz, 16'd1, 1'b0);
    vecs[1] = mk(tz, {7'd0, 7'd0, 7'd1, 7'd0}, 16'd16, 1'b0);
    vecs[2] = mk({9'h1FF, 9'd0, 9'd0, 9'd0}, {7'h7F, 7'd0, 7'd0, 7'd0}, 16'd65216, 1'b0);
    vecs[3] = mk({4{9'h1FF}}, {4{7'h7F}}, 16'hFFFF, 1'b1);
    vecs[4] = mk({9'd0, 9'h100, 9'd0, 9'd0}, bz, 16'd4096, 1'b0);
    vecs[5] = mk(tz, {7'd0, 7'd0, 7'd0, 7'h7F}, 16'd508, 1'b0);
    vecs[6] = mk({9'd0, 9'd0, 9'd3, 9'd0}, {7'd0, 7'd2, 7'd0, 7'd0}, 16'd140, 1'b0);
    vecs[7] = mk({9'h100, 9'd0, 9'd0, 9'd0}, {7'h40, 7'd0, 7'd0, 7'd0}, 16'd32768, 1'b0);
    vecs[8] = mk({9'h1FF, 9'd0, 9'd0, 9'd319}, {7'h7F, 7'd0, 7'd0, 7'd0}, 16'hFFFF, 1'b0);
    vecs[9] = mk({9'h1FF, 9'd0, 9'd0, 9'd320}, {7'h7F, 7'd0, 7'd0, 7'd0}, 16'hFFFF, 1'b1);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(tz, bz);

    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_product", int'(bus.product), 0);
    chk("rst_sat", int'(bus.sat), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    step(); step();
    #2 rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) send_check(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back A, B, C into a stalled consumer.
    bus.out_ready = 1'b0;
    drive({9'd0, 9'd0, 9'd0, 9'd1}, bz);
    bus.in_valid = 1'b1;
    #1 chk("abc_ready_a", int'(bus.in_ready), 1);
    step();
    drive({9'd0, 9'd0, 9'd1, 9'd0}, bz);
    #1 chk("abc_ready_b", int'(bus.in_ready), 1);
    step();
    drive({9'd0, 9'd1, 9'd0, 9'd0}, bz);
    #1 chk("abc_full", int'(bus.in_ready), 0);
    chk("abc_valid", int'(bus.out_valid), 1);
    chk("abc_hold_a", int'(bus.product), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abc_c_waits", int'(bus.in_ready), 0);
      chk("abc_hold_a", int'(bus.product), 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("abc_ready_rise", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("abc_out_b_valid", int'(bus.out_valid), 1);
    chk("abc_out_b", int'(bus.product), 4);
    step();
    chk("abc_out_c_valid", int'(bus.out_valid), 1);
    chk("abc_out_c", int'(bus.product), 16);
    step();
    chk("abc_empty", int'(bus.out_valid), 0);

    // Reset with two beats buffered.
    bus.out_ready = 1'b0;
    drive({9'd0, 9'd0, 9'd0, 9'd5}, bz);
    bus.in_valid = 1'b1;
    step();
    drive({9'd0, 9'd0, 9'd5, 9'd0}, bz);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_product", int'(bus.product), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    step(); step();
    #2 rst_n = 1'b1;
    step();
    send_check(mk({9'd2, 9'd0, 9'd0, 9'd0}, bz, 16'd128, 1'b0), "post_rst");

    // Random traffic against the scoreboard.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        t[k] = 9'($urandom);
        b[k] = 7'($urandom);
        if ($urandom_range(0, 3) == 0) t[k] = '0;
        if ($urandom_range(0, 3) == 0) b[k] = '0;
      end
      drive(t, b);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 20) begin
      step();
      guard++;
    end
    step();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", int'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
